// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token constants, token decoding helpers
// and the aligner FSM state type.
package tmds_pkg;

    typedef logic [9:0] tmds_word_t;

    localparam tmds_word_t TOKEN_C00 = 10'h354;
    localparam tmds_word_t TOKEN_C01 = 10'h0AB;
    localparam tmds_word_t TOKEN_C10 = 10'h154;
    localparam tmds_word_t TOKEN_C11 = 10'h2AB;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_e;

    function automatic logic is_ctrl_token(input tmds_word_t w);
        return (w == TOKEN_C00) || (w == TOKEN_C01) ||
               (w == TOKEN_C10) || (w == TOKEN_C11);
    endfunction

    // Returns {C1,C0}; non-token words decode to 0.
    function automatic logic [1:0] token_to_ctrl(input tmds_word_t w);
        case (w)
            TOKEN_C00: return 2'b00;
            TOKEN_C01: return 2'b01;
            TOKEN_C10: return 2'b10;
            TOKEN_C11: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_bit_shifter.sv
// Combinational 10:1 offset mux over the 20-bit window {current, previous};
// the previous word supplies the earliest (low) bits.
module tmds_bit_shifter
    import tmds_pkg::*;
(
    input  tmds_word_t cur_word_i,
    input  tmds_word_t prev_word_i,
    input  logic [3:0] offset_i,
    output tmds_word_t word_o
);

    logic [19:0] window;

    always_comb begin
        window = {cur_word_i, prev_word_i};
        // Offsets above 9 pass the current word straight through.
        case (offset_i)
            4'd0:    word_o = window[9:0];
            4'd1:    word_o = window[10:1];
            4'd2:    word_o = window[11:2];
            4'd3:    word_o = window[12:3];
            4'd4:    word_o = window[13:4];
            4'd5:    word_o = window[14:5];
            4'd6:    word_o = window[15:6];
            4'd7:    word_o = window[16:7];
            4'd8:    word_o = window[17:8];
            4'd9:    word_o = window[18:9];
            default: word_o = window[19:10];
        endcase
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// Per-channel TMDS word aligner: hunts for runs of control tokens at each bit
// offset, then locks and emits aligned symbols with decoded control bits.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] raw_word,
    input  logic       raw_valid,
    output logic [9:0] aligned_word,
    output logic       aligned_valid,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset,
    output logic       loss_pulse
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int DWELL_W = $clog2(SEARCH_TIMEOUT);
    localparam int TIMER_W = $clog2(LOSS_TIMEOUT);

    localparam logic [RUN_W-1:0]   RUN_FULL   = RUN_W'(CTRL_RUN);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LOSS_TIMEOUT - 1);

    align_state_e       state_q;
    tmds_word_t         prev_q;
    tmds_word_t         aligned_word_q;
    logic               aligned_valid_q;
    logic               is_ctrl_q;
    logic [1:0]         ctrl_q;
    logic [3:0]         offset_q;
    logic               loss_pulse_q;
    logic [RUN_W-1:0]   run_q;
    logic [RUN_W-1:0]   run_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [TIMER_W-1:0] timer_q;

    tmds_word_t candidate;
    logic       cand_is_token;

    tmds_bit_shifter u_shifter (
        .cur_word_i  (raw_word),
        .prev_word_i (prev_q),
        .offset_i    (offset_q),
        .word_o      (candidate)
    );

    assign cand_is_token = is_ctrl_token(candidate);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        run_d = run_q;
        if (raw_valid) begin
            if (!cand_is_token) begin
                run_d = '0;
            end else if (run_q != RUN_FULL) begin
                run_d = run_q + 1'b1;
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_SEARCH;
            prev_q          <= '0;
            aligned_word_q  <= '0;
            aligned_valid_q <= 1'b0;
            is_ctrl_q       <= 1'b0;
            ctrl_q          <= 2'b00;
            offset_q        <= 4'd0;
            loss_pulse_q    <= 1'b0;
            run_q           <= '0;
            dwell_q         <= '0;
            timer_q         <= '0;
        end else begin
            aligned_valid_q <= raw_valid;
            loss_pulse_q    <= 1'b0;
            if (raw_valid) begin
                prev_q         <= raw_word;
                aligned_word_q <= candidate;
                is_ctrl_q      <= cand_is_token;
                ctrl_q         <= token_to_ctrl(candidate);
                run_q          <= run_d;
                case (state_q)
                    ST_SEARCH: begin
                        if (run_d == RUN_FULL) begin
                            state_q <= ST_LOCKED;
                            dwell_q <= '0;
                            timer_q <= '0;
                        end else if (dwell_q == DWELL_LAST) begin
                            offset_q <= next_offset(offset_q);
                            dwell_q  <= '0;
                            run_q    <= '0;
                        end else begin
                            dwell_q <= dwell_q + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // A fresh full token run re-confirms the boundary.
                        if (run_d == RUN_FULL) begin
                            timer_q <= '0;
                        end else if (timer_q == TIMER_LAST) begin
                            state_q      <= ST_SEARCH;
                            loss_pulse_q <= 1'b1;
                            offset_q     <= next_offset(offset_q);
                            run_q        <= '0;
                            dwell_q      <= '0;
                            timer_q      <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    assign aligned_word  = aligned_word_q;
    assign aligned_valid = aligned_valid_q;
    assign is_ctrl       = is_ctrl_q;
    assign ctrl          = ctrl_q;
    assign locked        = (state_q == ST_LOCKED);
    assign offset        = offset_q;
    assign loss_pulse    = loss_pulse_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with shortened search/loss timeouts.
module tb_tmds_word_aligner;

    localparam logic [9:0] TK_C00 = 10'h354;
    localparam logic [9:0] TK_C01 = 10'h0AB;
    localparam logic [9:0] TK_C10 = 10'h154;
    localparam logic [9:0] TK_C11 = 10'h2AB;
    localparam int T1_LEN = 1216;

    logic       clk_pixel = 1'b0;
    logic       reset_n   = 1'b1;
    logic [9:0] raw_word  = '0;
    logic       raw_valid = 1'b0;
    logic [9:0] aligned_word;
    logic       aligned_valid;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;
    logic       loss_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk_pixel = ~clk_pixel;

    tmds_word_aligner #(
        .CTRL_RUN       (8),
        .SEARCH_TIMEOUT (256),
        .LOSS_TIMEOUT   (512)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset_n       (reset_n),
        .raw_word      (raw_word),
        .raw_valid     (raw_valid),
        .aligned_word  (aligned_word),
        .aligned_valid (aligned_valid),
        .is_ctrl       (is_ctrl),
        .ctrl          (ctrl),
        .locked        (locked),
        .offset        (offset),
        .loss_pulse    (loss_pulse)
    );

    function automatic logic tb_is_tok(input logic [9:0] w);
        return (w == TK_C00) || (w == TK_C01) || (w == TK_C10) || (w == TK_C11);
    endfunction

    function automatic logic [9:0] t1_pixel(input int j);
        logic [9:0] v;
        v = 10'(j * 173 + 91);
        if (tb_is_tok(v)) v = v ^ 10'h001;
        return v;
    endfunction

    // Transmitted word j: 16 C10 tokens at the start of every 200-word line.
    function automatic logic [9:0] t1_word(input int j);
        if (j < T1_LEN && (j % 200) < 16) return TK_C10;
        return t1_pixel(j);
    endfunction

    // Deserializer word j starts 7 bits into transmitted word j, so offset 3 is the boundary.
    function automatic logic [9:0] t1_raw(input int j);
        logic [9:0] w0;
        logic [9:0] w1;
        w0 = t1_word(j);
        w1 = t1_word(j + 1);
        return {w1[6:0], w0[9:7]};
    endfunction

    task automatic step(input logic [9:0] w, input logic v);
        raw_word  = w;
        raw_valid = v;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        raw_valid = 1'b0;
        raw_word  = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        raw_valid = 1'b1;
        raw_word  = TK_C00;
        repeat (2) @(posedge clk_pixel);
        #1;
        total++;
        if ({aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, loss_pulse} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got word=%h v=%b c=%b ctrl=%b lk=%b off=%0d loss=%b want all 0",
                     aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, loss_pulse);
        end
        raw_valid = 1'b0;
        reset_n   = 1'b1;
    endtask

    task automatic test_search_sweep();
        logic [15:0] lfsr;
        logic [9:0]  d;
        logic        lock_seen;
        int          exp_off;
        apply_reset();
        lfsr      = 16'hACE1;
        lock_seen = 1'b0;
        for (int c = 1; c <= 2560; c++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            d    = lfsr[9:0];
            if (tb_is_tok(d)) d = d ^ 10'h001;
            step(d, 1'b1);
            if (locked === 1'b1) lock_seen = 1'b1;
            if ((c % 256) == 0 || (c % 256) == 255) begin
                exp_off = (c / 256) % 10;
                total++;
                if (offset !== 4'(exp_off)) begin
                    bad++;
                    $display("FAIL sweep_offset@%0d: got %0d want %0d", c, offset, exp_off);
                end
            end
        end
        total++;
        if (lock_seen !== 1'b0) begin
            bad++;
            $display("FAIL sweep_no_lock: locked seen=%b want 0", lock_seen);
        end
    endtask

    task automatic test_run_threshold();
        logic [9:0] toks [4];
        logic       lock_seen;
        toks[0] = TK_C00;
        toks[1] = TK_C01;
        toks[2] = TK_C10;
        toks[3] = TK_C11;
        apply_reset();
        lock_seen = 1'b0;
        // At offset 0 the candidate is the previous raw word.
        for (int s = 0; s < 7; s++) begin
            step(toks[s % 4], 1'b1);
            if (locked === 1'b1) lock_seen = 1'b1;
            if (s >= 1 && s <= 4) begin
                total++;
                if ({aligned_word, is_ctrl, ctrl} !== {toks[(s - 1) % 4], 1'b1, 2'(s - 1)}) begin
                    bad++;
                    $display("FAIL decode_tok%0d: got word=%h c=%b ctrl=%b want word=%h c=1 ctrl=%0d",
                             s - 1, aligned_word, is_ctrl, ctrl, toks[(s - 1) % 4], s - 1);
                end
            end
        end
        for (int s = 0; s < 3; s++) begin
            step(10'h1F0, 1'b1);
            if (locked === 1'b1) lock_seen = 1'b1;
            if (s == 1) begin
                total++;
                if ({aligned_word, is_ctrl, ctrl} !== {10'h1F0, 1'b0, 2'b00}) begin
                    bad++;
                    $display("FAIL decode_data: got word=%h c=%b ctrl=%b want 1f0/0/0",
                             aligned_word, is_ctrl, ctrl);
                end
            end
        end
        total++;
        if (lock_seen !== 1'b0) begin
            bad++;
            $display("FAIL run7_no_lock: locked seen=%b want 0", lock_seen);
        end
        for (int s = 0; s < 8; s++) step(toks[s % 4], 1'b1);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL run8_early: locked=%b want 0 before 8th token is registered", locked);
        end
        step(10'h1F0, 1'b1);
        total++;
        if ({locked, offset} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL run8_lock: got locked=%b off=%0d want 1/0", locked, offset);
        end
    endtask

    task automatic test_lock_and_track();
        logic       lock_seen;
        int         lock_cycle;
        logic [3:0] lock_off;
        int         word_errs;
        int         ctrl_errs;
        int         tok_checked;
        logic [9:0] w;
        apply_reset();
        lock_seen   = 1'b0;
        lock_cycle  = -1;
        lock_off    = 4'd0;
        word_errs   = 0;
        ctrl_errs   = 0;
        tok_checked = 0;
        for (int j = 0; j < T1_LEN; j++) begin
            step(t1_raw(j), 1'b1);
            if (!lock_seen && locked === 1'b1) begin
                lock_seen  = 1'b1;
                lock_cycle = j;
                lock_off   = offset;
            end
            if (lock_seen) begin
                w = t1_word(j);
                if (aligned_word !== w || aligned_valid !== 1'b1) word_errs++;
                if (w == TK_C10) begin
                    tok_checked++;
                    if ({is_ctrl, ctrl} !== 3'b110) ctrl_errs++;
                end else if ({is_ctrl, ctrl} !== 3'b000) begin
                    ctrl_errs++;
                end
            end
        end
        total++;
        if (lock_cycle !== 807) begin
            bad++;
            $display("FAIL lock_cycle: got %0d want 807", lock_cycle);
        end
        total++;
        if (lock_off !== 4'd3) begin
            bad++;
            $display("FAIL lock_offset: got %0d want 3", lock_off);
        end
        total++;
        if (word_errs !== 0) begin
            bad++;
            $display("FAIL track_words: %0d wrong aligned words, want 0", word_errs);
        end
        total++;
        if (ctrl_errs !== 0 || tok_checked !== 41) begin
            bad++;
            $display("FAIL track_ctrl: errs=%0d tokens=%0d want 0 errs and 41 tokens",
                     ctrl_errs, tok_checked);
        end
    endtask

    task automatic test_loss();
        int pulses;
        pulses = 0;
        for (int j = T1_LEN; j <= 1730; j++) begin
            step(t1_raw(j), 1'b1);
            if (loss_pulse === 1'b1) pulses++;
            if (j == 1726) begin
                total++;
                if ({locked, loss_pulse} !== 2'b10) begin
                    bad++;
                    $display("FAIL loss_early: got locked=%b loss=%b want 1/0", locked, loss_pulse);
                end
            end
            if (j == 1727) begin
                total++;
                if ({locked, loss_pulse, offset} !== {1'b0, 1'b1, 4'd4}) begin
                    bad++;
                    $display("FAIL loss_event: got locked=%b loss=%b off=%0d want 0/1/4",
                             locked, loss_pulse, offset);
                end
            end
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL loss_pulse_width: got %0d pulse cycles want 1", pulses);
        end
    endtask

    task automatic test_valid_gap();
        apply_reset();
        for (int s = 0; s < 4; s++) step(TK_C11, 1'b1);
        for (int g = 0; g < 5; g++) begin
            step(10'h3FF, 1'b0);
            total++;
            if ({aligned_valid, aligned_word} !== {1'b0, TK_C11}) begin
                bad++;
                $display("FAIL gap_hold%0d: got v=%b word=%h want 0/%h", g, aligned_valid, aligned_word, TK_C11);
            end
        end
        for (int s = 0; s < 4; s++) begin
            step(TK_C11, 1'b1);
            if (s == 0) begin
                total++;
                if ({aligned_valid, is_ctrl, ctrl} !== 4'b1111) begin
                    bad++;
                    $display("FAIL gap_resume: got v=%b c=%b ctrl=%b want 1/1/11", aligned_valid, is_ctrl, ctrl);
                end
            end
        end
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL gap_early_lock: locked=%b want 0 after 7 counted tokens", locked);
        end
        step(10'h1F0, 1'b1);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL gap_lock: locked=%b want 1 after 8th token", locked);
        end
    endtask

    task automatic test_async_reset();
        step(TK_C11, 1'b1);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: locked=%b want 1", locked);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, loss_pulse} !== 20'h0) begin
            bad++;
            $display("FAIL areset_outputs: got word=%h v=%b c=%b ctrl=%b lk=%b off=%0d loss=%b want all 0",
                     aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, loss_pulse);
        end
        @(negedge clk_pixel);
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) step(10'h1F0, 1'b1);
        total++;
        if ({locked, offset, aligned_word} !== {1'b0, 4'd0, 10'h1F0}) begin
            bad++;
            $display("FAIL areset_release: got locked=%b off=%0d word=%h want 0/0/1f0",
                     locked, offset, aligned_word);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_search_sweep();
        test_run_threshold();
        test_lock_and_track();
        test_loss();
        test_valid_gap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
